// File: rtl/mac_feeder_pkg.sv
// Shared types and constants for the mac_col feeder: FSM states, the fixed
// load-burst length and the column instruction encodings.
package mac_feeder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KFILL,
        ST_LOAD,
        ST_EXEC,
        ST_FLUSH
    } state_e;

    localparam int LOAD_LEN = 10;
    localparam int LCNT_W   = $clog2(LOAD_LEN);

    localparam logic [1:0] INST_IDLE = 2'b00;
    localparam logic [1:0] INST_LOAD = 2'b01;
    localparam logic [1:0] INST_EXEC = 2'b10;

    // Leading load words are zero padding so column c captures its key at word 9-c.
    function automatic logic is_pad(input logic [LCNT_W-1:0] w, input int n_col);
        return int'(w) < (LOAD_LEN - n_col);
    endfunction

endpackage

// File: rtl/key_rev_buf.sv
// Key register file for the feeder: written in arrival order through an
// internal write index, read at an arbitrary index for the reversed burst.
module key_rev_buf #(
    parameter int  W     = 64,
    parameter int  DEPTH = 8,
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             wr_i,
    input  logic [W-1:0]     wr_data_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [W-1:0]     rd_data_o,
    output logic             wr_last_o
);

    logic [IDX_W-1:0] wr_idx_q;
    logic [W-1:0]     mem_q [DEPTH];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_idx_q <= '0;
        end else if (clr_i) begin
            wr_idx_q <= '0;
        end else if (wr_i) begin
            wr_idx_q <= wr_idx_q + 1'b1;
        end
    end

    // NOTE: the storage array has no reset; every slot is rewritten before it
    // is read, so resetting it would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (wr_i) begin
            mem_q[wr_idx_q] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_idx_i];
    assign wr_last_o = (wr_idx_q == IDX_W'(DEPTH - 1));

endmodule

// File: rtl/mac_feeder.sv
// Instruction/operand transmitter for column 0 of the mac_col array.
// Optional MAC_FEEDER_PERF_EN adds a saturating EXEC stall counter output.
module mac_feeder
    import mac_feeder_pkg::*;
#(
    parameter int bw     = 8,
    parameter int pr     = 8,
    parameter int col    = 8,
    parameter int qcnt_w = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [qcnt_w-1:0] n_query,
    input  logic              k_valid,
    output logic              k_ready,
    input  logic [pr*bw-1:0]  k_data,
    input  logic              q_valid,
    output logic              q_ready,
    input  logic [pr*bw-1:0]  q_data,
    output logic [1:0]        o_inst,
    output logic [pr*bw-1:0]  o_q,
    output logic              busy,
`ifdef MAC_FEEDER_PERF_EN
    output logic [15:0]       stall_cnt,
`endif
    output logic              done
);

    localparam int W     = pr * bw;
    localparam int IDX_W = (col > 1) ? $clog2(col) : 1;

    state_e            state_q, state_d;
    logic [LCNT_W-1:0] lcnt_q, lcnt_d;
    logic [qcnt_w-1:0] qcnt_q, qcnt_d;
    logic [qcnt_w-1:0] nq_q, nq_d;
    logic [1:0]        inst_q, inst_d;
    logic [W-1:0]      word_q, word_d;
    logic [W-1:0]      oq_q;
    logic              done_q, done_d;

    logic              k_hs, q_hs, start_acc, wr_last;
    logic [IDX_W-1:0]  rd_idx;
    logic [W-1:0]      key_rd, load_word;

    assign k_ready   = (state_q == ST_KFILL);
    assign q_ready   = (state_q == ST_EXEC);
    assign k_hs      = k_valid & k_ready;
    assign q_hs      = q_valid & q_ready;
    assign start_acc = start & (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);

    assign rd_idx    = IDX_W'(LOAD_LEN - 1 - int'(lcnt_q));
    assign load_word = is_pad(lcnt_q, col) ? '0 : key_rd;

    key_rev_buf #(
        .W     (W),
        .DEPTH (col)
    ) u_kbuf (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (start_acc),
        .wr_i      (k_hs),
        .wr_data_i (k_data),
        .rd_idx_i  (rd_idx),
        .rd_data_o (key_rd),
        .wr_last_o (wr_last)
    );

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        lcnt_d  = lcnt_q;
        qcnt_d  = qcnt_q;
        nq_d    = nq_q;
        inst_d  = INST_IDLE;
        word_d  = '0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_KFILL;
                    nq_d    = n_query;
                    qcnt_d  = '0;
                end
            end
            ST_KFILL: begin
                // Word 0 issues on the last key handshake so LOAD follows without a gap.
                if (k_hs && wr_last) begin
                    inst_d  = INST_LOAD;
                    word_d  = load_word;
                    lcnt_d  = lcnt_q + 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                inst_d = INST_LOAD;
                word_d = load_word;
                lcnt_d = lcnt_q + 1'b1;
                if (lcnt_q == LCNT_W'(LOAD_LEN - 1)) begin
                    lcnt_d  = '0;
                    state_d = (nq_q == '0) ? ST_FLUSH : ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (q_hs) begin
                    inst_d = INST_EXEC;
                    word_d = q_data;
                    qcnt_d = qcnt_q + 1'b1;
                    if (qcnt_d == nq_q) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            lcnt_q  <= '0;
            qcnt_q  <= '0;
            nq_q    <= '0;
            inst_q  <= INST_IDLE;
            word_q  <= '0;
            oq_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lcnt_q  <= lcnt_d;
            qcnt_q  <= qcnt_d;
            nq_q    <= nq_d;
            inst_q  <= inst_d;
            word_q  <= word_d;
            oq_q    <= word_q;
            done_q  <= done_d;
        end
    end

    assign o_inst = inst_q;
    assign o_q    = oq_q;
    assign done   = done_q;

`ifdef MAC_FEEDER_PERF_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (start_acc) begin
            stall_cnt_q <= '0;
        end else if ((state_q == ST_EXEC) && !q_valid && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/mac_feeder.md
# mac_feeder

Instruction/operand transmitter for the `mac_col` systolic array. Accepts keys and queries from the host on two valid/ready streams and drives the array's first column with the `{execute, load}` instruction pair and the matching `pr*bw` operand word. Buffers and reverses the key set, pads the load burst to the columns' fixed capture schedule, and skews operands one cycle behind instructions so each column samples the intended word. Sits between the host-side SRAM/DMA and column 0.

## Interface
- `bw`, 8, operand element width
- `pr`, 8, elements per word (word = `pr*bw` bits)
- `col`, 8, number of columns, 1..8
- `qcnt_w`, 8, width of the query-count field
- `clk` input 1 clock
- `reset` input 1 asynchronous, active-high reset
- `start` input 1 one-cycle pulse; latches `n_query`, begins a load+execute pass
- `n_query` input `qcnt_w` number of queries in this pass; 0 means load only
- `k_valid` / `k_ready` input/output 1 key stream handshake
- `k_data` input `pr*bw` key word; keys arrive in column order 0..col-1
- `q_valid` / `q_ready` input/output 1 query stream handshake
- `q_data` input `pr*bw` query word
- `o_inst` output 2 to column 0 `i_inst`: [1] execute, [0] load
- `o_q` output `pr*bw` to column 0 `q_in`
- `busy` output 1 high from accepted `start` until `done`
- `done` output 1 one-cycle pulse at pass end

## Operation
- States: IDLE, KFILL, LOAD, EXEC, FLUSH.
- IDLE: `busy`=0, `k_ready`=`q_ready`=0. `start` -> KFILL and latch `n_query`. `start` outside IDLE is ignored.
- KFILL: `k_ready`=1. Each handshake writes `k_data` to key slot `kidx` (0..col-1). After slot col-1 -> LOAD.
- LOAD: exactly 10 words (LOAD_LEN), `o_inst`=01 each cycle, one per cycle, no stalls. Word index w: w < 10-col emits zero; otherwise emits key slot `9-w`. Column c therefore receives its key at word `9-c`. After word 9 -> EXEC, or FLUSH if `n_query`=0.
- EXEC: `q_ready`=1 while queries remain. Accepted query -> `o_inst`=10 and that word on `o_q` next cycle. `q_valid`=0 -> bubble, `o_inst`=00. After `n_query` accepted -> FLUSH.
- FLUSH: `o_inst`=00 one cycle; `done` pulses; -> IDLE.
- The array latches keys only once per reset; a second pass after `done` without reset issues load words that the columns ignore. This is required and the feeder still emits the full burst.

## Timing
- Reset values: `o_inst`=00, `o_q`=0, `busy`=0, `done`=0, `k_ready`=`q_ready`=0, state IDLE, all counters 0.
- `o_inst` registered from the state/handshake; `o_q` is the word for that instruction, registered one further cycle. Word for `o_inst` at cycle t appears on `o_q` at t+1.
- Between a LOAD burst and the first EXEC word, `o_inst` must not go to 00 unless `q_valid` is low. Bubbles are legal anywhere in EXEC.
- `start`-to-first-LOAD-word latency = col key handshakes + 1 cycle.
- `reset` mid-pass returns to IDLE immediately. Key buffer contents are don't-care; `o_inst` drops to 00 asynchronously.
- `k_valid`/`q_valid` in other states: not accepted, no side effects.

## Configuration
- `MAC_FEEDER_PERF_EN` defined: adds output `stall_cnt` (16 bits, saturating). It counts EXEC cycles with `q_valid`=0, clears on `start`, and is 0 at reset.
- `MAC_FEEDER_PERF_EN` undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- `mac_feeder_pkg`: state enum, `LOAD_LEN`=10, instruction encodings `INST_IDLE`=00, `INST_LOAD`=01, `INST_EXEC`=10.
- Sub-module `key_rev_buf`: col-entry key register file with a write index and a read index.

## Test plan
- col=8, keys K0..K7 = 0x01..0x08 replicated, n_query=0 -> LOAD words on `o_q` are 0,0,K7,K6,…,K0 with `o_inst`=01 one cycle earlier. Each `mac_col` instance c holds key Kc. `done` occurs 1 cycle after the last load word.
- n_query=4, `q_valid` always high -> 4 consecutive `o_inst`=10 following LOAD. `o_q` equals Q0..Q3 lagged 1 cycle. Column 0 `fifo_wr` pulses 4 times.
- n_query=3, `q_valid` low for 2 cycles after Q0 -> `o_inst` 10,00,00,10,10, and `stall_cnt`=2 with the macro defined.
- col=4 -> LOAD words: 6 zeros then K3..K0.
- Reset asserted during LOAD word 5 -> `o_inst`=00 and `busy`=0 immediately. A new `start` after reset runs a clean full pass.
- `start` pulsed while busy -> ignored. `n_query` change mid-pass has no effect.
